// File: rtl/ones_checksum_ctrl_if.sv
// Handshake and result bundle between a frame source and the ones'-complement checksum controller.
interface ones_checksum_ctrl_if #(
    parameter int unsigned LEN_W = 4
);
    localparam int unsigned WORD_W = 4;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic [WORD_W-1:0] sum_out;
    logic [WORD_W-1:0] chk_out;
    logic              done;
    logic              err;

    modport master (
        output start, len, abort, in_valid, in_data,
        input  in_ready, busy, sum_out, chk_out, done, err
    );

    modport slave (
        input  start, len, abort, in_valid, in_data,
        output in_ready, busy, sum_out, chk_out, done, err
    );
endinterface

// File: rtl/ones_checksum_ctrl.sv
// Accumulates a framed stream of 4-bit words into a ones'-complement sum and reports sum and checksum.
module ones_checksum_ctrl #(
    parameter int unsigned LEN_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    ones_checksum_ctrl_if.slave bus
);
    localparam int unsigned WORD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] chk_q, chk_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // End-around carry add; a second carry is impossible for 4-bit operands.
    function automatic logic [WORD_W-1:0] ones_add(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WORD_W-1:0] + WORD_W'(s[WORD_W]);
    endfunction

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                // Abort takes priority; a word offered in the same cycle is dropped.
                if (bus.abort) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.in_valid) begin
                    acc_d = ones_add(acc_q, bus.in_data);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they line up with it after the edge.
        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        chk_d      = ~acc_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            chk_q      <= '1;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            chk_q      <= chk_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.sum_out  = acc_q;
    assign bus.chk_out  = chk_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ones_checksum_ctrl.sv
// Directed test of ones_checksum_ctrl: sums, end-around carry, gaps, zero length, abort and async reset.
module tb_ones_checksum_ctrl;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   done_cnt;

    ones_checksum_ctrl_if #(.LEN_W(4)) bus ();

    ones_checksum_ctrl #(.LEN_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [3:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        step();
        bus.start = 1'b0;
        bus.len   = 4'h0;
    endtask

    task automatic word(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        bus.start    = 1'b0;
        bus.len      = 4'h0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        reset_n      = 1'b0;
        #12;
        check("rst_in_ready", 8'(bus.in_ready), 8'h0);
        check("rst_busy",     8'(bus.busy),     8'h0);
        check("rst_done",     8'(bus.done),     8'h0);
        check("rst_err",      8'(bus.err),      8'h0);
        check("rst_sum",      8'(bus.sum_out),  8'h0);
        check("rst_chk",      8'(bus.chk_out),  8'hF);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Basic sum 3+5
        frame_start(4'd2);
        check("b_in_ready", 8'(bus.in_ready), 8'h1);
        check("b_busy",     8'(bus.busy),     8'h1);
        word(4'h3);
        check("b_sum1",     8'(bus.sum_out),  8'h3);
        check("b_done0",    8'(bus.done),     8'h0);
        word(4'h5);
        check("b_done",     8'(bus.done),     8'h1);
        check("b_sum",      8'(bus.sum_out),  8'h8);
        check("b_chk",      8'(bus.chk_out),  8'h7);
        check("b_rdy_done", 8'(bus.in_ready), 8'h0);
        check("b_busy_dn",  8'(bus.busy),     8'h1);
        step();
        check("b_done_off", 8'(bus.done),     8'h0);
        check("b_busy_off", 8'(bus.busy),     8'h0);
        check("b_sum_hold", 8'(bus.sum_out),  8'h8);

        // End-around carry F+1, then back-to-back 9+8+7
        frame_start(4'd2);
        word(4'hF);
        word(4'h1);
        check("c1_sum",  8'(bus.sum_out), 8'h1);
        check("c1_chk",  8'(bus.chk_out), 8'hE);
        check("c1_done", 8'(bus.done),    8'h1);
        step();
        frame_start(4'd3);
        check("c2_clear", 8'(bus.sum_out), 8'h0);
        word(4'h9);
        word(4'h8);
        check("c2_mid",  8'(bus.sum_out), 8'h2);
        word(4'h7);
        check("c2_sum",  8'(bus.sum_out), 8'h9);
        check("c2_chk",  8'(bus.chk_out), 8'h6);
        check("c2_done", 8'(bus.done),    8'h1);
        step();

        // Gaps of two idle cycles, start ignored mid-frame
        done_cnt = 0;
        frame_start(4'd3);
        word(4'h1);
        bus.start = 1'b1;
        bus.len   = 4'd5;
        step();
        bus.start = 1'b0;
        bus.len   = 4'd0;
        step();
        check("g_sum_gap", 8'(bus.sum_out),  8'h1);
        check("g_rdy_gap", 8'(bus.in_ready), 8'h1);
        word(4'h2);
        step();
        step();
        check("g_done_gap", 8'(bus.done), 8'h0);
        word(4'h4);
        check("g_sum",  8'(bus.sum_out), 8'h7);
        check("g_done", 8'(bus.done),    8'h1);
        step();
        step();
        step();
        check("g_done_cnt", 8'(done_cnt), 8'h1);

        // Zero-length frame, abort ignored in IDLE
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("i_abort_err", 8'(bus.err), 8'h0);
        frame_start(4'd0);
        check("z_done",  8'(bus.done),     8'h1);
        check("z_rdy",   8'(bus.in_ready), 8'h0);
        check("z_busy",  8'(bus.busy),     8'h1);
        check("z_sum",   8'(bus.sum_out),  8'h0);
        check("z_chk",   8'(bus.chk_out),  8'hF);
        step();
        check("z_done_off", 8'(bus.done), 8'h0);

        // Abort after A+3 = D, with a word offered in the abort cycle
        done_cnt = 0;
        frame_start(4'd4);
        word(4'hA);
        word(4'h3);
        check("a_part", 8'(bus.sum_out), 8'hD);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h5;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        check("a_err",   8'(bus.err),      8'h1);
        check("a_done",  8'(bus.done),     8'h0);
        check("a_sum",   8'(bus.sum_out),  8'hD);
        check("a_chk",   8'(bus.chk_out),  8'h2);
        check("a_rdy",   8'(bus.in_ready), 8'h0);
        check("a_busy",  8'(bus.busy),     8'h0);
        step();
        check("a_err_off", 8'(bus.err), 8'h0);
        check("a_no_done", 8'(done_cnt), 8'h0);

        // Async reset mid-frame with sum 6
        frame_start(4'd3);
        word(4'h2);
        word(4'h4);
        check("r_pre_sum", 8'(bus.sum_out), 8'h6);
        #2;
        reset_n = 1'b0;
        #1;
        check("r_rdy",  8'(bus.in_ready), 8'h0);
        check("r_busy", 8'(bus.busy),     8'h0);
        check("r_sum",  8'(bus.sum_out),  8'h0);
        check("r_chk",  8'(bus.chk_out),  8'hF);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        frame_start(4'd1);
        word(4'hC);
        check("r_new_sum",  8'(bus.sum_out), 8'hC);
        check("r_new_chk",  8'(bus.chk_out), 8'h3);
        check("r_new_done", 8'(bus.done),    8'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
